// File: rtl/div_unit.sv
// Iterative 32-bit divider for RV32M DIV/DIVU/REM/REMU.
// Uses a one-bit-per-cycle restoring algorithm on operand magnitudes, then applies a sign fix-up.
// Divide-by-zero and signed overflow skip the iteration and complete on the accept edge.
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        div_valid_i,
   output logic        div_ready_o,
   input  logic [1:0]  div_op_i,
   input  logic [31:0] div_a_i,
   input  logic [31:0] div_b_i,
   input  logic        div_flush_i,
   output logic [31:0] div_o,
   output logic        div_valid_o,
   input  logic        div_ready_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_reg;
   state_t      state_next;
   logic [4:0]  cnt_reg;
   logic [31:0] rem_reg;
   logic [31:0] quo_reg;
   logic [31:0] abs_b_reg;
   logic [1:0]  op_reg;
   logic        neg_q_reg;
   logic        neg_r_reg;
   logic [31:0] div_o_reg;

   // Operand decode at the accept edge.
   logic        accept;
   logic        signed_op;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic        b_zero;
   logic        sign_ovf;

   assign accept    = (state_reg == IDLE) && div_valid_i && !div_flush_i;
   assign signed_op = !div_op_i[0];
   assign a_neg     = signed_op && div_a_i[31];
   assign b_neg     = signed_op && div_b_i[31];
   assign abs_a     = a_neg ? (~div_a_i + 32'd1) : div_a_i;
   assign abs_b     = b_neg ? (~div_b_i + 32'd1) : div_b_i;
   assign b_zero    = (div_b_i == 32'd0);
   assign sign_ovf  = signed_op && (div_a_i == 32'h8000_0000) && (div_b_i == 32'hFFFF_FFFF);

   // One restoring step: shift {rem,quo} left, try subtracting |b|.
   // The shifted remainder can exceed 32 bits, so its top bit forces "no borrow".
   logic [32:0] shifted;
   logic [32:0] trial;
   logic        no_borrow;
   logic [31:0] rem_step;
   logic [31:0] quo_step;
   logic [31:0] quo_fixed;
   logic [31:0] rem_fixed;
   logic        last_step;

   assign shifted   = {rem_reg, quo_reg[31]};
   assign trial     = shifted - {1'b0, abs_b_reg};
   assign no_borrow = shifted[32] || !trial[32];
   assign rem_step  = no_borrow ? trial[31:0] : shifted[31:0];
   assign quo_step  = {quo_reg[30:0], no_borrow};
   assign quo_fixed = neg_q_reg ? (~quo_step + 32'd1) : quo_step;
   assign rem_fixed = neg_r_reg ? (~rem_step + 32'd1) : rem_step;
   assign last_step = (state_reg == CALC) && (cnt_reg == 5'd31);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and handshake outputs; flush overrides every transition.
   always_comb begin
      state_next  = state_reg;
      div_ready_o = (state_reg == IDLE);
      div_valid_o = (state_reg == DONE);
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = (b_zero || sign_ovf) ? DONE : CALC;
            end
         end
         CALC: begin
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (div_ready_i) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (div_flush_i) begin
         state_next = IDLE;
      end
   end

   // Datapath: latch operands on accept, iterate in CALC, load the result on the final step.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg   <= 5'd0;
         rem_reg   <= 32'd0;
         quo_reg   <= 32'd0;
         abs_b_reg <= 32'd0;
         op_reg    <= 2'd0;
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
         div_o_reg <= 32'd0;
      end else if (accept) begin
         cnt_reg   <= 5'd0;
         rem_reg   <= 32'd0;
         quo_reg   <= abs_a;
         abs_b_reg <= abs_b;
         op_reg    <= div_op_i;
         neg_q_reg <= a_neg ^ b_neg;
         neg_r_reg <= a_neg;
         if (b_zero) begin
            div_o_reg <= div_op_i[1] ? div_a_i : 32'hFFFF_FFFF;
         end else if (sign_ovf) begin
            div_o_reg <= div_op_i[1] ? 32'd0 : 32'h8000_0000;
         end
      end else if ((state_reg == CALC) && !div_flush_i) begin
         cnt_reg <= cnt_reg + 5'd1;
         rem_reg <= rem_step;
         quo_reg <= quo_step;
         if (last_step) begin
            div_o_reg <= op_reg[1] ? rem_fixed : quo_fixed;
         end
      end
   end

   assign div_o = div_o_reg;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The module SHALL have no parameters; the datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 div_valid_i  input  1  upstream request valid.
REQ-005 div_ready_o  output  1  unit can accept a request.
REQ-006 div_op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M funct3[1:0]).
REQ-007 div_a_i  input  32  dividend.
REQ-008 div_b_i  input  32  divisor.
REQ-009 div_flush_i  input  1  abort the in-flight operation (pipeline flush).
REQ-010 div_o  output  32  result (quotient or remainder per op).
REQ-011 div_valid_o  output  1  div_o valid.
REQ-012 div_ready_i  input  1  downstream consumes the result.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-014 div_ready_o SHALL be 1 exactly when state is IDLE; div_valid_o SHALL be 1 exactly when state is DONE.
REQ-015 Accept SHALL occur on an edge with div_valid_i=1, div_ready_o=1, div_flush_i=0; op, operands, |a|, |b|, and sign flags SHALL be latched then.
REQ-016 Signed ops SHALL divide magnitudes; the quotient SHALL be negated when operand signs differ; the remainder SHALL take the dividend's sign.
REQ-017 Divisor zero: on accept, next state SHALL be DONE with quotient 0xFFFFFFFF and remainder = dividend, for both signed and unsigned ops.
REQ-018 Signed overflow (a=0x80000000, b=0xFFFFFFFF, op DIV/REM): on accept, next state SHALL be DONE with quotient 0x80000000 and remainder 0.
REQ-019 Otherwise the FSM SHALL enter CALC with a 5-bit step counter cleared, partial remainder 0, and quotient register = |a|.
REQ-020 Each CALC cycle SHALL perform one restoring step: shift {rem,quo} left by 1; compute 33-bit trial = rem - |b|; if no borrow, rem<=trial and quo[0]<=1, else quo[0]<=0.
REQ-021 After the step at counter value 31, the FSM SHALL apply the sign fix-up, load div_o, and go to DONE; normal latency is 33 edges from accept to div_valid_o=1.
REQ-022 In DONE, div_o and div_valid_o SHALL hold stable until an edge with div_ready_i=1; that edge SHALL return the FSM to IDLE.
REQ-023 A new request SHALL NOT be accepted in the cycle a result is consumed; the earliest next accept is the following edge.
REQ-024 div_flush_i=1 SHALL force IDLE on the next edge from any state and discard the result; flush SHALL take priority over accept and over consume.
REQ-025 Inputs SHALL be ignored outside the accept edge; operand changes during CALC SHALL NOT affect the result.

Reset
REQ-026 rst=1 on an edge SHALL set state IDLE, counter 0, internal registers 0, div_o=0x00000000, div_valid_o=0, and therefore div_ready_o=1.
REQ-027 rst SHALL take priority over flush, accept, and consume, including mid-CALC and in DONE; no result SHALL be emitted for an interrupted operation.

Verification
REQ-028 DIVU 100/7 -> div_valid_o rises 33 edges after accept, div_o=0x0000000E; REMU same operands -> 0x00000002.
REQ-029 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM 0xFFFFFFF9/2 -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-030 DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 0x00000005, DIV 0x80000000/0xFFFFFFFF -> 0x80000000; each valid 1 edge after accept.
REQ-031 Result with div_ready_i held 0 for 5 cycles -> div_o and div_valid_o stable; div_ready_i=1 -> IDLE next edge, div_ready_o=1.
REQ-032 div_flush_i at CALC step 10 -> div_valid_o never asserts, div_ready_o=1 next edge; an immediately following DIVU 9/3 -> 0x00000003.
REQ-033 rst asserted in DONE and at CALC step 20 -> all outputs at reset values next edge; no stale result appears afterwards.
